// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl -- MEM-stage data memory access controller.
//
// Turns a load/store sitting in the EX/MEM register into a request on the
// data memory port. The pipeline is held (stall_n=0) until the memory
// acknowledges or a wait limit expires. A timeout sets a sticky error flag.
//
// Optional feature, selected at compile time:
//   MEM_STAGE_RDBUF_EN - one-entry read buffer (valid, addr, data). A load to
//                        the buffered address completes in IDLE with no
//                        memory request and no stall.
//
// Memory handshake: dmem_req rises on the clock edge that enters BUSY.
// dmem_req, dmem_we, dmem_addr and dmem_wdata then stay stable until the
// access ends. The memory answers with a single-cycle dmem_ack, and
// dmem_rdata is valid in that same cycle. An ack that arrives while no
// request is outstanding (IDLE or DONE) is ignored.
module mem_stage_ctrl #(
   parameter int unsigned MAX_WAIT = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ex_MemRead,
   input  logic        ex_MemWrite,
   input  logic        ex_WriteReg,
   input  logic [15:0] ex_ALU_res,
   input  logic [15:0] ex_store_data,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [15:0] dmem_addr,
   output logic [15:0] dmem_wdata,
   input  logic [15:0] dmem_rdata,
   input  logic        dmem_ack,
   output logic        mem_WriteReg,
   output logic [15:0] mem_ALU_res,
   output logic [15:0] mem_data_mem,
   output logic        stall_n,
   output logic        mem_err,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // The wait counter starts at 0 on entry to BUSY, so BUSY lasts MAX_WAIT
   // cycles when the counter value LAST_CNT is the final one.
   localparam logic [7:0] LAST_CNT = 8'(MAX_WAIT - 1);

   state_t      state_q, state_d;
   logic        req_q, req_d;
   logic        we_q, we_d;
   logic [15:0] addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;
   logic [15:0] rdata_q, rdata_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        err_q, err_d;

   logic        mem_op;
   logic        is_load;
   logic        buf_hit;

   assign mem_op  = ex_MemRead | ex_MemWrite;
   // A load with the write bit also set counts as a store.
   assign is_load = ex_MemRead & ~ex_MemWrite;

`ifdef MEM_STAGE_RDBUF_EN
   logic        buf_valid_q, buf_valid_d;
   logic [15:0] buf_addr_q, buf_addr_d;
   logic [15:0] buf_data_q, buf_data_d;

   // A buffer hit is only meaningful for a load that has not started a memory access yet.
   always_comb begin
      buf_hit = (state_q == IDLE) && is_load && buf_valid_q &&
                (buf_addr_q == ex_ALU_res);
   end
`else
   // No buffer in this build, so a hit can never happen.
   always_comb begin
      buf_hit = 1'b0;
   end
`endif

   // Next-state and next-register computation for the access FSM.
   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
`ifdef MEM_STAGE_RDBUF_EN
      buf_valid_d = buf_valid_q;
      buf_addr_d  = buf_addr_q;
      buf_data_d  = buf_data_q;
`endif
      case (state_q)
         IDLE: begin
            if (mem_op && !buf_hit) begin
               state_d = BUSY;
               req_d   = 1'b1;
               we_d    = ex_MemWrite;
               addr_d  = ex_ALU_res;
               wdata_d = ex_store_data;
               cnt_d   = 8'd0;
            end
         end
         BUSY: begin
            if (dmem_ack) begin
               // An ack wins over a timeout that would happen on the same edge.
               state_d = DONE;
               req_d   = 1'b0;
               if (!we_q) begin
                  rdata_d = dmem_rdata;
               end
`ifdef MEM_STAGE_RDBUF_EN
               buf_valid_d = 1'b1;
               buf_addr_d  = addr_q;
               buf_data_d  = we_q ? wdata_q : dmem_rdata;
`endif
            end else if (cnt_q == LAST_CNT) begin
               state_d = DONE;
               req_d   = 1'b0;
               err_d   = 1'b1;
               if (!we_q) begin
                  rdata_d = 16'h0000;
               end
`ifdef MEM_STAGE_RDBUF_EN
               buf_valid_d = 1'b0;
`endif
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            req_d   = 1'b0;
         end
      endcase
   end

   // All controller state is registered here. Reset abandons any access in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= 16'h0000;
         wdata_q <= 16'h0000;
         rdata_q <= 16'h0000;
         cnt_q   <= 8'd0;
         err_q   <= 1'b0;
`ifdef MEM_STAGE_RDBUF_EN
         buf_valid_q <= 1'b0;
         buf_addr_q  <= 16'h0000;
         buf_data_q  <= 16'h0000;
`endif
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
`ifdef MEM_STAGE_RDBUF_EN
         buf_valid_q <= buf_valid_d;
         buf_addr_q  <= buf_addr_d;
         buf_data_q  <= buf_data_d;
`endif
      end
   end

   // The stall is combinational so the pipeline freezes in the cycle the op is detected.
   always_comb begin
      stall_n = 1'b1;
      case (state_q)
         IDLE:    stall_n = !(mem_op && !buf_hit);
         BUSY:    stall_n = 1'b0;
         DONE:    stall_n = 1'b1;
         default: stall_n = 1'b1;
      endcase
   end

   // Load data goes to MEM/WB. On a buffer hit the buffer supplies it directly.
   always_comb begin
`ifdef MEM_STAGE_RDBUF_EN
      mem_data_mem = buf_hit ? buf_data_q : rdata_q;
`else
      mem_data_mem = buf_hit ? 16'h0000 : rdata_q;
`endif
   end

   assign dmem_req     = req_q;
   assign dmem_we      = we_q;
   assign dmem_addr    = addr_q;
   assign dmem_wdata   = wdata_q;
   assign mem_err      = err_q;
   assign mem_WriteReg = ex_WriteReg;
   assign mem_ALU_res  = ex_ALU_res;
   assign dbg_state    = state_q;

endmodule
